// File: rtl/result_bcd_display_pkg.sv
// Shared constants for the result BCD display: FSM encodings, 7-segment patterns
// and the double-dabble nibble correction.
package result_bcd_display_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0   = 7'h40;
    localparam logic [6:0] SEG_1   = 7'h79;
    localparam logic [6:0] SEG_2   = 7'h24;
    localparam logic [6:0] SEG_3   = 7'h30;
    localparam logic [6:0] SEG_4   = 7'h19;
    localparam logic [6:0] SEG_5   = 7'h12;
    localparam logic [6:0] SEG_6   = 7'h02;
    localparam logic [6:0] SEG_7   = 7'h78;
    localparam logic [6:0] SEG_8   = 7'h00;
    localparam logic [6:0] SEG_9   = 7'h10;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    function automatic logic [3:0] dd_adjust(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

endpackage

// File: rtl/result_bcd_display_seg7_decode.sv
// BCD nibble to active-low 7-segment pattern; non-decimal codes are dark.
module seg7_decode
    import result_bcd_display_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_OFF;
        unique case (nibble_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/result_bcd_display.sv
// Captures a result on the rising edge of ready, converts it to BCD by double dabble
// and scans it onto a multiplexed common-anode display with leading-zero blanking.
module result_bcd_display
    import result_bcd_display_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DIGITS   = 3,
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  busy,
    output logic                  result_valid,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an
);

    localparam int unsigned PreW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [WIDTH-1:0] CntLoad = WIDTH'(WIDTH);

    state_e                state_q, state_d;
    logic                  ready_q;
    logic [WIDTH-1:0]      shreg_q, shreg_d;
    logic [4*DIGITS-1:0]   work_q, work_d;
    logic [WIDTH-1:0]      cnt_q, cnt_d;
    logic                  pend_q, pend_d;
    logic [WIDTH-1:0]      pend_data_q, pend_data_d;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d;
    logic                  valid_q, valid_d;
    logic                  blank_q, blank_d;
    logic [PreW-1:0]       pre_q, pre_d;
    logic [IdxW-1:0]       idx_q, idx_d;

    logic                  rise;
    logic                  start;
    logic [4*DIGITS-1:0]   adj;
    logic [3:0]            nib;
    logic [6:0]            dec_seg;
    logic                  lit;

    assign rise  = ready & ~ready_q;
    // DONE restarts on a queued value or on an edge arriving in the DONE cycle itself
    assign start = (state_q == S_IDLE && rise) || (state_q == S_DONE && (rise || pend_q));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            ready_q     <= 1'b0;
            shreg_q     <= '0;
            work_q      <= '0;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            pend_data_q <= '0;
            bcd_q       <= '0;
            valid_q     <= 1'b0;
            blank_q     <= 1'b1;
            pre_q       <= '0;
            idx_q       <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready;
            shreg_q     <= shreg_d;
            work_q      <= work_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            pend_data_q <= pend_data_d;
            bcd_q       <= bcd_d;
            valid_q     <= valid_d;
            blank_q     <= blank_d;
            pre_q       <= pre_d;
            idx_q       <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (rise) state_d = S_SHIFT;
            S_SHIFT: if (cnt_q == WIDTH'(1)) state_d = S_DONE;
            S_DONE:  state_d = (rise || pend_q) ? S_SHIFT : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < int'(DIGITS); i++) begin
            adj[4*i +: 4] = dd_adjust(work_q[4*i +: 4]);
        end
    end

    always_comb begin
        shreg_d     = shreg_q;
        work_d      = work_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        pend_data_d = pend_data_q;
        bcd_d       = bcd_q;
        valid_d     = 1'b0;
        blank_d     = blank_q;
        if (state_q == S_SHIFT) begin
            {work_d, shreg_d} = {adj[4*DIGITS-2:0], shreg_q, 1'b0};
            cnt_d             = cnt_q - WIDTH'(1);
        end
        if (state_q == S_DONE) begin
            bcd_d   = work_q;
            valid_d = 1'b1;
            blank_d = 1'b0;
            pend_d  = 1'b0;
        end
        if (start) begin
            shreg_d = (rise || !pend_q) ? in_data : pend_data_q;
            work_d  = '0;
            cnt_d   = CntLoad;
        end else if (rise && state_q == S_SHIFT) begin
            pend_d      = 1'b1;
            pend_data_d = in_data;
        end
    end

    always_comb begin
        pre_d = pre_q + PreW'(1);
        idx_d = idx_q;
        if (pre_q == PreW'(SCAN_DIV - 1)) begin
            pre_d = '0;
            idx_d = (idx_q == IdxW'(DIGITS - 1)) ? '0 : idx_q + IdxW'(1);
        end
    end

    assign nib = bcd_q[{idx_q, 2'b00} +: 4];
    assign lit = (idx_q == '0) || ((bcd_q >> {idx_q, 2'b00}) != '0);

    seg7_decode u_seg7_decode (
        .nibble_i (nib),
        .seg_o    (dec_seg)
    );

    always_comb begin
        busy         = (state_q == S_SHIFT) || (state_q == S_DONE);
        result_valid = valid_q;
        bcd          = bcd_q;
        an           = '1;
        seg          = SEG_OFF;
        if (!blank_q && lit) begin
            an[idx_q] = 1'b0;
            seg       = dec_seg;
        end
    end

endmodule

// File: tb/tb_result_bcd_display.sv
// Scoreboard bench: stimulus queues expected BCD results, a monitor checks each result_valid.
module tb_result_bcd_display;

    logic        clock = 1'b0;
    logic        reset;
    logic        ready;
    logic [7:0]  in_data;
    logic        busy;
    logic        result_valid;
    logic [11:0] bcd;
    logic [6:0]  seg;
    logic [2:0]  an;

    int checks = 0;
    int errors = 0;
    int valid_cnt = 0;
    logic [11:0] sb[$];

    always #5 clock = ~clock;

    result_bcd_display #(.WIDTH(8), .DIGITS(3), .SCAN_DIV(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .ready        (ready),
        .in_data      (in_data),
        .busy         (busy),
        .result_valid (result_valid),
        .bcd          (bcd),
        .seg          (seg),
        .an           (an)
    );

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every result_valid pulse pops one expected value
    initial begin
        logic [11:0] exp;
        forever begin
            @(negedge clock);
            if (reset === 1'b1 && result_valid === 1'b1) begin
                valid_cnt++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got bcd 0x%0h expected no pulse", bcd);
                end else begin
                    exp = sb.pop_front();
                    check("bcd_result", {20'h0, bcd}, {20'h0, exp});
                end
            end
        end
    end

    task automatic pulse(input logic [7:0] v);
        @(negedge clock);
        #1 ready = 1'b0;
        @(negedge clock);
        #1 in_data = v;
        ready = 1'b1;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        check("scoreboard_drain", sb.size(), 0);
    endtask

    task automatic scan_check(input logic [11:0] val, input logic [2:0] mask);
        logic [2:0] seen = 3'b000;
        int bad = 0;
        int nlow;
        for (int s = 0; s < 24; s++) begin
            @(negedge clock);
            nlow = 0;
            for (int d = 0; d < 3; d++) begin
                if (an[d] == 1'b0) begin
                    nlow++;
                    seen[d] = 1'b1;
                    if (seg !== seg_of(val[4*d +: 4])) bad++;
                end
            end
            if (nlow > 1) bad++;
            if (nlow == 0 && seg !== 7'h7F) bad++;
        end
        check("scan_digits_lit", {29'h0, seen}, {29'h0, mask});
        check("scan_seg_errors", bad, 0);
    endtask

    initial begin
        int v0;
        int busy_cnt;
        int valid_at;
        logic [11:0] bmask;
        logic [2:0] prev_an;
        logic [2:0] exp_an;
        logic [6:0] exp_seg;
        int bad;
        int n;

        reset = 1'b0;
        ready = 1'b0;
        in_data = 8'h00;
        repeat (3) @(negedge clock);
        #1 reset = 1'b1;

        // Idle after reset: blank display, nothing happening
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            check("idle_state", {an, seg, bcd, busy, result_valid},
                  {3'b111, 7'h7F, 12'h000, 1'b0, 1'b0});
        end

        // 0x55 -> 085, latency and busy window
        pulse(8'h55);
        sb.push_back(12'h085);
        busy_cnt = 0;
        valid_at = 0;
        bmask = '0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clock);
            if (busy) begin
                busy_cnt++;
                bmask[i-1] = 1'b1;
            end
            if (result_valid && valid_at == 0) valid_at = i;
        end
        check("busy_cycles", busy_cnt, 9);
        check("busy_window", {20'h0, bmask}, {20'h0, 12'h1FF});
        check("valid_latency", valid_at, 10);
        wait_drain(5);
        scan_check(12'h085, 3'b011);

        pulse(8'hFF);
        sb.push_back(12'h255);
        wait_drain(30);
        scan_check(12'h255, 3'b111);

        pulse(8'h00);
        sb.push_back(12'h000);
        wait_drain(30);
        scan_check(12'h000, 3'b001);

        // Back-to-back edges: 2 is overwritten by 3 in the pending buffer
        v0 = valid_cnt;
        pulse(8'd1);
        sb.push_back(12'h001);
        repeat (2) @(negedge clock);
        pulse(8'd2);
        pulse(8'd3);
        sb.push_back(12'h003);
        wait_drain(60);
        repeat (15) @(negedge clock);
        check("queued_valid_count", valid_cnt - v0, 2);
        check("queued_final_bcd", {20'h0, bcd}, {20'h0, 12'h003});

        // Reset mid-conversion
        v0 = valid_cnt;
        pulse(8'd200);
        repeat (4) @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check("abort_state", {an, seg, bcd, busy, result_valid},
              {3'b111, 7'h7F, 12'h000, 1'b0, 1'b0});
        ready = 1'b0;
        @(negedge clock);
        #1 reset = 1'b1;
        repeat (15) @(negedge clock);
        check("abort_no_valid", valid_cnt - v0, 0);
        check("abort_bcd", {20'h0, bcd}, 32'h0);
        pulse(8'd42);
        sb.push_back(12'h042);
        wait_drain(30);

        // Scan timing with 123
        pulse(8'd123);
        sb.push_back(12'h123);
        wait_drain(30);
        prev_an = an;
        n = 0;
        @(negedge clock);
        while (!(an == 3'b110 && prev_an != 3'b110) && n < 40) begin
            prev_an = an;
            @(negedge clock);
            n++;
        end
        check("scan_sync_found", (n < 40) ? 1 : 0, 1);
        bad = 0;
        for (int i = 0; i < 13; i++) begin
            if (i < 4 || i == 12) begin exp_an = 3'b110; exp_seg = 7'h30; end
            else if (i < 8)       begin exp_an = 3'b101; exp_seg = 7'h24; end
            else                  begin exp_an = 3'b011; exp_seg = 7'h79; end
            if (an !== exp_an || seg !== exp_seg) bad++;
            if (i < 12) @(negedge clock);
        end
        check("scan_sequence_errors", bad, 0);

        check("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
